// File: rtl/parity_serial_scheduler.sv
// Purpose : round-robin share of one bit-serial parity engine among N_REQ parallel-word requesters.
// Latency : gnt in cycle T, ser_x bits T..T+WIDTH-1 LSB-first, done/parity/done_id in cycle T+WIDTH.
// Backpressure: req is held by the requester until its gnt pulse; req is ignored while a word shifts.
// Option  : define RR_BACK2BACK_EN to arbitrate in DONE as well (no IDLE bubble, WIDTH+1 cycles per word).
module parity_serial_scheduler #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] data,
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic                   ser_x,
   output logic                   ser_valid,
   output logic                   done,
   output logic [ID_W-1:0]        done_id,
   output logic                   parity
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  shreg;
   logic [CNT_W-1:0]  cnt;
   logic              acc;
   logic [ID_W-1:0]   last;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   idx;
   logic              found;
   logic              load;
   logic              last_bit;

   assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
   assign busy      = (state != IDLE);
   assign ser_valid = (state == SHIFT);
   assign ser_x     = shreg[0];

   // Round-robin search: first set req bit starting just above the last winner, wrapping around.
   always_comb begin
      winner = last;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(last) + k) % N_REQ);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // Next-state logic; load marks the edge at which a new word is captured and granted.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
`ifdef RR_BACK2BACK_EN
            if (|req) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: capture word on grant, shift LSB-first while accumulating parity, publish result on last bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg   <= '0;
         cnt     <= '0;
         acc     <= 1'b0;
         last    <= ID_W'(N_REQ - 1);
         gnt     <= '0;
         done    <= 1'b0;
         done_id <= '0;
         parity  <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         if (load) begin
            shreg <= data[winner*WIDTH +: WIDTH];
            cnt   <= '0;
            acc   <= 1'b0;
            last  <= winner;
            gnt   <= N_REQ'(1) << winner;
         end else if (state == SHIFT) begin
            acc   <= acc ^ shreg[0];
            shreg <= shreg >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
               parity  <= acc ^ shreg[0];
               done_id <= last;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/parity_serial_scheduler.md
Name: parity_serial_scheduler

Overview:
Shares one bit-serial parity engine between N_REQ parallel-word requesters. It arbitrates round-robin, latches the winning word, and shifts it LSB-first through the serial parity tracker, one bit per clk. It then reports the parity and the requester ID. It sits in front of the serial parity detector datapath and sequences its x input.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, bits per word (2..32)
ID_W, $clog2(N_REQ), width of requester ID

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
req  input  N_REQ  per-requester request; held until its gnt bit is seen
data  input  N_REQ*WIDTH  per-requester word; slice i = data[i*WIDTH +: WIDTH]
gnt  output  N_REQ  registered one-hot grant, one-cycle pulse
busy  output  1  high in SHIFT and DONE
ser_x  output  1  bit currently fed to the parity engine (shreg[0])
ser_valid  output  1  high while ser_x is meaningful (SHIFT)
done  output  1  one-cycle result pulse
done_id  output  ID_W  requester the result belongs to; held until next done
parity  output  1  XOR of all WIDTH bits (1 = odd number of ones); held until next done

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - gnt=0, busy=0, ser_x=0, ser_valid=0, done=0, done_id=0, parity=0.
  - Shift register and bit counter cleared.
  - RR pointer last=N_REQ-1, so req[0] has top priority first.
  - Reset mid-SHIFT or mid-DONE discards the word: no done, no gnt.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - At an edge with req!=0, the winner is the first set bit searching from last+1 upward with wrap.
  - That edge: shreg<=data slice, cnt<=0, acc<=0, last<=winner, gnt<=onehot(winner), state<=SHIFT.
  - With req==0, stay in IDLE.
- SHIFT:
  - gnt is high only in the first SHIFT cycle.
  - Each edge: acc<=acc^shreg[0], shreg<=shreg>>1, cnt<=cnt+1.
  - At the edge with cnt==WIDTH-1: parity<=acc^shreg[0], done_id<=last, done<=1, state<=DONE.
  - req is ignored throughout SHIFT.
- DONE: one cycle, done=1, then IDLE on the next edge.
- Timing:
  - gnt in cycle T, done in cycle T+WIDTH.
  - Default throughput: one word per WIDTH+2 cycles.
- Edge cases:
  - A requester that keeps req high after gnt is treated as a new request and re-arbitrated fairly.
  - req changing during SHIFT has no effect.
  - Words of all zeros or all ones are legal.

Optional Feature:
Macro: RR_BACK2BACK_EN
- Defined:
  - DONE also performs IDLE's arbitration at its edge.
  - If req!=0, the next gnt lands in the cycle immediately after DONE; there is no IDLE bubble.
  - Throughput is one word per WIDTH+1 cycles.
  - busy stays high across back-to-back words.
- Undefined: DONE always returns to IDLE, as described above.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req=4'hF -> all outputs 0, no gnt. Release -> gnt=4'b0001 on the first grant.
2. Single word: req[0]=1 with data0=8'b1011_0010.
   - gnt[0] in cycle T; ser_x sequence 0,1,0,0,1,1,0,1.
   - done at T+8 with parity=0, done_id=0.
   - Repeat with data0=8'h07 -> parity=1.
3. Fairness: req=4'hF held (each requester re-asserts) -> grants 0,1,2,3,0.
   - Default build: gnt spacing 10 cycles.
   - RR_BACK2BACK_EN build: spacing 9 cycles, busy never drops.
4. Two contenders: req[1] and req[3] held constantly -> grants alternate 1,3,1,3; done_id matches each grant.
5. Reset mid-operation: rst_n=0 at the 4th SHIFT cycle of a word from req[2] -> no done. After release, arbitration restarts at req[0].
6. Data change during SHIFT: change data0 to 8'hFF after gnt -> parity reflects the latched word only.
